// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port round-robin front end for the unified memory.
// Ports: cpu_* (port 0) and dbg_* (port 1) req/gnt/ack, mem_* macro side,
// busy/owner status. Every output is registered; Reset is sync active-high.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state, stateNext;

  logic [CW-1:0] cnt, cntN;
  logic          lastGrant, lastGrantN;
  logic          anyReq, winner;

  logic          cpuGntN, dbgGntN, cpuAckN, dbgAckN;
  logic [DW-1:0] cpuRdataN, dbgRdataN;
  logic          memEnN, memWeN;
  logic [AW-1:0] memAddrN;
  logic [DW-1:0] memWdataN;
  logic          busyN, ownerN;

  assign anyReq = cpu_req | dbg_req;
  // On a tie the port that did not win last time takes it.
  assign winner = (cpu_req & dbg_req) ? ~lastGrant : dbg_req;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lastGrant <= 1'b1;
      cpu_gnt   <= 1'b0;
      dbg_gnt   <= 1'b0;
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      owner     <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntN;
      lastGrant <= lastGrantN;
      cpu_gnt   <= cpuGntN;
      dbg_gnt   <= dbgGntN;
      cpu_ack   <= cpuAckN;
      dbg_ack   <= dbgAckN;
      cpu_rdata <= cpuRdataN;
      dbg_rdata <= dbgRdataN;
      mem_en    <= memEnN;
      mem_we    <= memWeN;
      mem_addr  <= memAddrN;
      mem_wdata <= memWdataN;
      busy      <= busyN;
      owner     <= ownerN;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (anyReq) stateNext = BUSY;
      BUSY:    if (cnt == '0) stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    cntN       = cnt;
    lastGrantN = lastGrant;
    cpuGntN    = 1'b0;
    dbgGntN    = 1'b0;
    cpuAckN    = 1'b0;
    dbgAckN    = 1'b0;
    cpuRdataN  = cpu_rdata;
    dbgRdataN  = dbg_rdata;
    memEnN     = mem_en;
    memWeN     = mem_we;
    memAddrN   = mem_addr;
    memWdataN  = mem_wdata;
    busyN      = busy;
    ownerN     = owner;
    unique case (state)
      IDLE: begin
        if (anyReq) begin
          lastGrantN = winner;
          ownerN     = winner;
          memEnN     = 1'b1;
          memWeN     = winner ? dbg_we : cpu_we;
          memAddrN   = winner ? dbg_addr : cpu_addr;
          memWdataN  = winner ? dbg_wdata : cpu_wdata;
          cpuGntN    = ~winner;
          dbgGntN    = winner;
          cntN       = CNT_INIT;
          busyN      = 1'b1;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          memEnN  = 1'b0;
          memWeN  = 1'b0;
          cpuAckN = ~owner;
          dbgAckN = owner;
          // mem_we still reflects the access being finished here.
          if (!mem_we) begin
            if (owner) dbgRdataN = mem_rdata;
            else       cpuRdataN = mem_rdata;
          end
        end else begin
          cntN = cnt - CW'(1);
        end
      end
      RESP: busyN = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single-ported unified memory between two requesters.
  - Port 0 is the multicycle CPU controller, for instruction fetch and load/store.
  - Port 1 is the debug/program loader.
- Sequences each access over a fixed memory latency.
- Returns read data and a one-cycle completion pulse to the owning requester.
- Sits between the controller/datapath memory interface and the memory macro.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MEM_LAT, 2, cycles mem_en is held per access. Must be >=1; mem_rdata is valid in the last of these cycles.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- cpu_req  input  1  CPU access request; held until cpu_ack.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  AW  access address.
- cpu_wdata  input  DW  write data.
- cpu_gnt  output  1  one-cycle pulse: CPU request accepted.
- cpu_ack  output  1  one-cycle pulse: CPU access complete.
- cpu_rdata  output  DW  read data; valid with cpu_ack and held until the next CPU read.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_ack, dbg_rdata: same as cpu_* for port 1.
- mem_en  output  1  memory access enable.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data.
- busy  output  1  high in BUSY and RESP states.
- owner  output  1  port of the current or last access: 0 = CPU, 1 = dbg.

Behaviour:
- All outputs are registered.
- Reset values: all gnt/ack/mem_* outputs = 0; all rdata = 0; busy = 0; owner = 0; state = IDLE; cnt = 0; last_grant = 1, so the CPU wins the first tie.
- Reset during BUSY or RESP aborts the access: mem_en drops at that edge and no ack is issued.
- State machine:
  - IDLE → BUSY, at any edge where a req is high.
  - BUSY → RESP, at the edge where cnt == 0.
  - RESP → IDLE, unconditionally.
- Arbitration in IDLE:
  - Only one req high: grant that port.
  - Both high: grant the port != last_grant (round-robin).
  - Then last_grant <= winner and owner <= winner.
- Grant edge E, in IDLE:
  - Latch the winner's we/addr/wdata into mem_we/mem_addr/mem_wdata.
  - mem_en <= 1, winner's gnt <= 1, cnt <= MEM_LAT-1, busy <= 1.
- gnt is a pulse: cleared at edge E+1.
- BUSY:
  - mem_en, mem_we, mem_addr and mem_wdata are held stable.
  - cnt decrements each edge while non-zero.
- BUSY edge with cnt == 0 (edge E+MEM_LAT):
  - mem_en <= 0 and mem_we <= 0.
  - Owner's ack <= 1.
  - On a read, owner's rdata <= mem_rdata. On a write, rdata is unchanged.
  - Enter RESP.
- RESP edge (E+MEM_LAT+1): ack <= 0, busy <= 0, return to IDLE.
- Earliest next grant edge: E+MEM_LAT+2.
- Requester rules:
  - A requester samples ack at the edge ending RESP and deasserts req there.
  - A req still high in the following IDLE cycle is a new access.
  - Inputs are ignored outside IDLE. A req dropped after grant does not abort the access; ack is still issued.
- The non-owner's req is left pending; it receives no gnt until granted in a later IDLE.
- At most one gnt and one ack are high in any cycle.
- mem_we is never high while mem_en is low.
- No address or data arithmetic; widths pass through unchanged.

Test Plan:
- MEM_LAT=2, CPU read at addr 0x10; memory returns 0xDEADBEEF in the last mem_en cycle → cpu_gnt pulses at E; mem_en is high for exactly 2 cycles with mem_addr=0x10, mem_we=0; cpu_ack pulses at E+2; cpu_rdata=0xDEADBEEF; dbg_rdata stays 0.
- After reset, cpu_req and dbg_req rise in the same cycle → CPU granted first; dbg is granted at edge E+4; then both re-request → CPU, dbg, CPU alternate (owner 0,1,0).
- dbg write addr 0x40, data 0x12345678 → mem_we=1, mem_addr=0x40, mem_wdata=0x12345678 held for 2 cycles; dbg_ack pulses; dbg_rdata unchanged.
- Reset asserted at edge E+1 of a CPU read → mem_en, busy and gnt are 0 at E+1; no cpu_ack ever; next request is granted normally with CPU priority.
- MEM_LAT=1, CPU read → mem_en is high for 1 cycle; cpu_ack at E+1; next grant possible at E+3.
- CPU drops cpu_req one cycle after gnt → access still completes and cpu_ack pulses once; no second grant occurs.
